ir_key_display: RTL and testbench

IR_KEY_DISPLAY -- requirements
Module: ir_key_display

---
 rtl/ir_pkg.sv | 50 +++++
 rtl/seg7_encode.sv | 30 +++
 rtl/ir_key_display.sv | 124 ++++++++++++
 tb/tb_ir_key_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - NEC command-to-key map and seven-segment code constants
package ir_pkg;

   localparam logic [7:0] CMD_KEY0 = 8'h68;
   localparam logic [7:0] CMD_KEY1 = 8'h30;
   localparam logic [7:0] CMD_KEY2 = 8'h18;
   localparam logic [7:0] CMD_KEY3 = 8'h7A;
   localparam logic [7:0] CMD_KEY4 = 8'h10;
   localparam logic [7:0] CMD_KEY5 = 8'h38;
   localparam logic [7:0] CMD_KEY6 = 8'h5A;
   localparam logic [7:0] CMD_KEY7 = 8'h42;
   localparam logic [7:0] CMD_KEY8 = 8'h4A;
   localparam logic [7:0] CMD_KEY9 = 8'h52;

   localparam logic [3:0] KEY_UNMAPPED = 4'hF;

   // Active-low segment codes: bit 7 = dp, bits 6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [3:0] cmd_to_key(input logic [7:0] cmd);
      logic [3:0] key;
      key = KEY_UNMAPPED;
      case (cmd)
         CMD_KEY0: key = 4'd0;
         CMD_KEY1: key = 4'd1;
         CMD_KEY2: key = 4'd2;
         CMD_KEY3: key = 4'd3;
         CMD_KEY4: key = 4'd4;
         CMD_KEY5: key = 4'd5;
         CMD_KEY6: key = 4'd6;
         CMD_KEY7: key = 4'd7;
         CMD_KEY8: key = 4'd8;
         CMD_KEY9: key = 4'd9;
         default:  key = KEY_UNMAPPED;
      endcase
      return key;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational key-to-segment encoder, blank when slot unoccupied
module seg7_encode
   import ir_pkg::*;
(
   input  logic [3:0] key,
   input  logic       occupied,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (occupied) begin
         case (key)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/ir_key_display.sv
// rtl/ir_key_display.sv - NEC frame checker, 4-key history and multiplexed 7-segment display
module ir_key_display
   import ir_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int SCAN_DIV    = 50_000,
   parameter int TIMEOUT_CYC = 500_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic [31:0] frame_data,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [7:0]  err_cnt,
   output logic [3:0]  DIG,
   output logic [7:0]  SEG
);

   // A non-positive SCAN_DIV falls back to a 1 kHz digit rate derived from CLK_HZ
   localparam int SCAN_DIV_EFF = (SCAN_DIV > 0) ? SCAN_DIV :
                                 ((CLK_HZ / 1000) > 0) ? (CLK_HZ / 1000) : 1;
   localparam int SCAN_W = (SCAN_DIV_EFF > 1) ? $clog2(SCAN_DIV_EFF) : 1;
   localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV_EFF - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

   logic              key_valid_q, key_valid_d;
   logic [3:0]        key_code_q,  key_code_d;
   logic [7:0]        err_cnt_q,   err_cnt_d;
   logic [3:0][3:0]   slot_key_q,  slot_key_d;
   logic [3:0]        slot_occ_q,  slot_occ_d;
   logic [SCAN_W-1:0] scan_cnt_q,  scan_cnt_d;
   logic [1:0]        idx_q,       idx_d;
   logic [IDLE_W-1:0] idle_q,      idle_d;
   logic [3:0]        dig_q,       dig_d;
   logic [7:0]        seg_q,       seg_d;

   logic       accept;
   logic       reject;
   logic       scan_wrap;
   logic       timed_out;
   logic [3:0] new_key;
   logic [7:0] sel_seg;

   seg7_encode u_seg7_encode (
      .key      (slot_key_q[idx_q]),
      .occupied (slot_occ_q[idx_q]),
      .seg      (sel_seg)
   );

   always_comb begin
      accept    = frame_valid && (frame_data[31:24] == ~frame_data[23:16])
                              && (frame_data[15:8]  == ~frame_data[7:0]);
      reject    = frame_valid && !accept;
      new_key   = cmd_to_key(frame_data[15:8]);
      scan_wrap = (scan_cnt_q == SCAN_MAX);
      timed_out = (idle_q == IDLE_MAX);

      key_valid_d = accept;
      key_code_d  = key_code_q;
      err_cnt_d   = err_cnt_q;
      slot_key_d  = slot_key_q;
      slot_occ_d  = slot_occ_q;

      if (accept) begin
         key_code_d = new_key;
         slot_key_d = {slot_key_q[2:0], new_key};
         slot_occ_d = {slot_occ_q[2:0], 1'b1};
      end

      if (reject && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

      if (accept) begin
         idle_d = '0;
      end else if (timed_out) begin
         idle_d = idle_q;
      end else begin
         idle_d = idle_q + IDLE_W'(1);
      end

      // History stays intact while blanked; only the drive to the panel is suppressed
      dig_d = timed_out ? 4'b1111   : ~(4'b0001 << idx_q);
      seg_d = timed_out ? SEG_BLANK : sel_seg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         err_cnt_q   <= 8'h00;
         slot_key_q  <= '0;
         slot_occ_q  <= 4'b0000;
         scan_cnt_q  <= '0;
         idx_q       <= 2'd0;
         idle_q      <= '0;
         dig_q       <= 4'b1111;
         seg_q       <= SEG_BLANK;
      end else begin
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         err_cnt_q   <= err_cnt_d;
         slot_key_q  <= slot_key_d;
         slot_occ_q  <= slot_occ_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         idle_q      <= idle_d;
         dig_q       <= dig_d;
         seg_q       <= seg_d;
      end
   end

   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign err_cnt   = err_cnt_q;
   assign DIG       = dig_q;
   assign SEG       = seg_q;

endmodule

// File: tb/tb_ir_key_display.sv
// tb/tb_ir_key_display.sv - scoreboard bench for ir_key_display with a queue-based reference model
module tb_ir_key_display;

   localparam int SCAN_DIV    = 4;
   localparam int TIMEOUT_CYC = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_valid;
   logic [31:0] frame_data;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [7:0]  err_cnt;
   logic [3:0]  DIG;
   logic [7:0]  SEG;

   always #5 clk = ~clk;

   ir_key_display #(
      .CLK_HZ      (50_000_000),
      .SCAN_DIV    (SCAN_DIV),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .err_cnt     (err_cnt),
      .DIG         (DIG),
      .SEG         (SEG)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  key;
      int unsigned cyc;
   } exp_t;

   exp_t exp_q[$];
   int   hist[$];     // newest key first, at most four entries
   int   model_err = 0;

   logic [7:0] cmd_tab [10] = '{8'h68, 8'h30, 8'h18, 8'h7A, 8'h10,
                                8'h38, 8'h5A, 8'h42, 8'h4A, 8'h52};
   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   function automatic int key_of(input logic [7:0] cmd);
      for (int k = 0; k < 10; k++) begin
         if (cmd_tab[k] == cmd) return k;
      end
      return 15;
   endfunction

   function automatic logic [7:0] seg_of_slot(input int slot);
      if (slot >= hist.size()) return 8'hFF;
      if (hist[slot] < 10) return seg_tab[hist[slot]];
      return 8'h8E;
   endfunction

   function automatic logic [31:0] mk_frame(input logic [7:0] addr, input logic [7:0] cmd);
      return {addr, ~addr, cmd, ~cmd};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every key_valid pulse must match the oldest outstanding accept
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_key_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("key_code", {28'd0, key_code}, {28'd0, e.key});
            check("key_latency", cyc, e.cyc);
         end
      end
   end

   task automatic send_frame(input logic [31:0] d);
      exp_t e;
      int   k;
      frame_valid = 1'b1;
      frame_data  = d;
      if ((d[31:24] == ~d[23:16]) && (d[15:8] == ~d[7:0])) begin
         k     = key_of(d[15:8]);
         e.key = 4'(k);
         e.cyc = cyc + 1;
         exp_q.push_back(e);
         hist.push_front(k);
         if (hist.size() > 4) void'(hist.pop_back());
      end else if (model_err < 255) begin
         model_err++;
      end
      @(posedge clk); #1;
      frame_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_display(input string tag);
      logic [3:0] want_dig;
      int         n;
      idle(2);
      for (int i = 0; i < 4; i++) begin
         want_dig = ~(4'b0001 << i);
         n = 0;
         @(negedge clk);
         while (DIG !== want_dig && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (DIG !== want_dig) check($sformatf("%s_dig%0d_timeout", tag, i), {28'd0, DIG}, {28'd0, want_dig});
         else check($sformatf("%s_slot%0d", tag, i), {24'd0, SEG}, {24'd0, seg_of_slot(i)});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  cmd;

      rst_n       = 1'b0;
      frame_valid = 1'b0;
      frame_data  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("rst_dig", {28'd0, DIG}, 32'hF);
      check("rst_seg", {24'd0, SEG}, 32'hFF);
      rst_n = 1'b1;
      idle(1);

      send_frame(32'h00FF6897);
      check_display("key0");

      for (int k = 1; k <= 5; k++) begin
         idle($urandom_range(0, 2));
         send_frame(mk_frame(8'($urandom), cmd_tab[k]));
      end
      check_display("keys1to5");

      send_frame(32'h00FF6896);
      check("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
      check_display("after_bad");

      send_frame(32'h00FF11EE);
      check_display("unmapped");

      // Mixed traffic: mapped/unmapped commands, corrupted complements, back-to-back frames
      for (int n = 0; n < 40; n++) begin
         idle($urandom_range(0, 3));
         cmd = ($urandom_range(0, 3) != 0) ? cmd_tab[$urandom_range(0, 9)] : 8'($urandom);
         d   = mk_frame(8'($urandom), cmd);
         if ($urandom_range(0, 3) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
         send_frame(d);
      end
      check_display("random");
      check("random_err_cnt", {24'd0, err_cnt}, 32'(model_err));

      for (int n = 0; n < 300; n++) begin
         d = $urandom;
         if ((d[31:24] == ~d[23:16]) && (d[15:8] == ~d[7:0])) d[0] = ~d[0];
         send_frame(d);
      end
      idle(1);
      check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

      idle(TIMEOUT_CYC + 10);
      for (int n = 0; n < 4; n++) begin
         check("timeout_dig", {28'd0, DIG}, 32'hF);
         check("timeout_seg", {24'd0, SEG}, 32'hFF);
         idle(3);
      end
      send_frame(mk_frame(8'($urandom), cmd_tab[7]));
      check_display("restore");

      idle(5);
      rst_n       = 1'b0;
      frame_valid = 1'b1;
      frame_data  = mk_frame(8'h00, cmd_tab[0]);
      @(posedge clk); #1;
      frame_valid = 1'b0;
      hist.delete();
      model_err = 0;
      check("rst2_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst2_key_code", {28'd0, key_code}, 32'd0);
      check("rst2_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("rst2_dig", {28'd0, DIG}, 32'hF);
      check("rst2_seg", {24'd0, SEG}, 32'hFF);
      rst_n = 1'b1;
      check_display("post_reset");

      send_frame(mk_frame(8'h5A, cmd_tab[9]));
      check_display("after_reset_key");

      idle(4);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
